quad_step_sequencer: RTL and testbench

Command-driven quadrature pattern generator that drives the `quadA`/`quadB` lines consumed by the quadrature counter in the stepper FPGA. It accepts move commands (target position plus step period) over a valid/ready handshake and steps the A/B phases toward the target, one quarter-step per period. It tracks its own position and reports completion. The block sequences the counter datapath from the generating side. In the system it is the motion engine between the command interface and the stepper driver/counter.

---
 rtl/quad_step_sequencer_if.sv | 25 ++
 rtl/quad_step_sequencer.sv | 138 +++++++++++++
 tb/tb_quad_step_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/quad_step_sequencer_if.sv
// Move-command channel for the quadrature step sequencer.
// The master side presents target and period with valid; the sequencer slave returns ready.
interface quad_step_sequencer_if #(
  parameter int unsigned POS_BITS = 16,
  parameter int unsigned DIV_BITS = 16
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [POS_BITS-1:0] cmd_target;
  logic [DIV_BITS-1:0] cmd_period;

  modport master (
    output cmd_valid,
    output cmd_target,
    output cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    input  cmd_period,
    output cmd_ready
  );
endinterface

// File: rtl/quad_step_sequencer.sv
// Command-driven quadrature A/B generator: steps toward an absolute target,
// one quarter-step per programmed period, and pulses done when the move ends.
module quad_step_sequencer #(
  parameter int unsigned POS_BITS = 16,
  parameter int unsigned DIV_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  quad_step_sequencer_if.slave cmd,
  input  logic                abort,
  output logic                quadA,
  output logic                quadB,
  output logic [POS_BITS-1:0] position,
  output logic                busy,
  output logic                done,
  output logic                aborted
);

  localparam logic [POS_BITS-1:0] HALF_RANGE = {1'b1, {(POS_BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_SETTLE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_BITS-1:0] cnt_q, cnt_d;
  logic [DIV_BITS-1:0] per_q, per_d;
  logic [POS_BITS-1:0] tgt_q, tgt_d;
  logic [POS_BITS-1:0] pos_q, pos_d;
  logic                a_q, a_d;
  logic                b_q, b_d;
  logic                done_q, done_d;
  logic                abt_q, abt_d;

  logic [DIV_BITS-1:0] per_eff;
  logic                step_rev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      tgt_q   <= '0;
      pos_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      tgt_q   <= tgt_d;
      pos_q   <= pos_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
      abt_q   <= abt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    tgt_d   = tgt_q;
    pos_d   = pos_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    abt_d   = 1'b0;

    per_eff  = (cmd.cmd_period == '0) ? DIV_BITS'(1) : cmd.cmd_period;
    // Upper half of the modular distance means the target is closer going backwards.
    step_rev = (POS_BITS'(tgt_q - pos_q) >= HALF_RANGE);

    unique case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          tgt_d   = cmd.cmd_target;
          per_d   = per_eff;
          cnt_d   = per_eff - DIV_BITS'(1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          abt_d   = 1'b1;
        end else if (pos_q == tgt_q) begin
          state_d = S_SETTLE;
          cnt_d   = per_q - DIV_BITS'(1);
        end else if (cnt_q == '0) begin
          // Gray walk: forward 00->10->11->01, reverse is the mirror.
          cnt_d = per_q - DIV_BITS'(1);
          if (step_rev) begin
            pos_d = pos_q - POS_BITS'(1);
            a_d   = b_q;
            b_d   = ~a_q;
          end else begin
            pos_d = pos_q + POS_BITS'(1);
            a_d   = ~b_q;
            b_d   = a_q;
          end
        end else begin
          cnt_d = cnt_q - DIV_BITS'(1);
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          abt_d   = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - DIV_BITS'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign busy          = (state_q == S_RUN) || (state_q == S_SETTLE);
  assign quadA         = a_q;
  assign quadB         = b_q;
  assign position      = pos_q;
  assign done          = done_q;
  assign aborted       = abt_q;

endmodule

// File: tb/tb_quad_step_sequencer.sv
// Directed bench for quad_step_sequencer: a 16-bit instance for moves, abort and
// handshake, and a 5-bit instance for modular wrap behaviour.
module tb_quad_step_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  quad_step_sequencer_if #(.POS_BITS(16), .DIV_BITS(16)) cmd_if ();
  logic        abort;
  logic        quadA, quadB, busy, done, aborted;
  logic [15:0] position;

  quad_step_sequencer #(.POS_BITS(16), .DIV_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd_if), .abort(abort),
    .quadA(quadA), .quadB(quadB), .position(position),
    .busy(busy), .done(done), .aborted(aborted)
  );

  quad_step_sequencer_if #(.POS_BITS(5), .DIV_BITS(16)) cmd5_if ();
  logic       abort5;
  logic       quadA5, quadB5, busy5, done5, aborted5;
  logic [4:0] position5;

  quad_step_sequencer #(.POS_BITS(5), .DIV_BITS(16)) dut5 (
    .clk(clk), .rst_n(rst_n), .cmd(cmd5_if), .abort(abort5),
    .quadA(quadA5), .quadB(quadB5), .position(position5),
    .busy(busy5), .done(done5), .aborted(aborted5)
  );

  // Quadrature phase expected at a given quarter-step position.
  function automatic logic [1:0] ab_of(input int p);
    case (p & 3)
      0:       ab_of = 2'b00;
      1:       ab_of = 2'b10;
      2:       ab_of = 2'b11;
      default: ab_of = 2'b01;
    endcase
  endfunction

  // Present one command at the current negedge; returns at the first cycle after accept.
  task automatic cmd_go(input logic [15:0] t, input logic [15:0] p);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = t;
    cmd_if.cmd_period = p;
    @(negedge clk);
    cmd_if.cmd_valid  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({quadA, quadB} !== 2'b00 || position !== 16'd0) begin bad++; $display("FAIL reset_out ab=%b pos=%0d exp ab=00 pos=0", {quadA, quadB}, position); end
    total++; if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_flags busy=%b done=%b abt=%b rdy=%b exp 0 0 0 1", busy, done, aborted, cmd_if.cmd_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    cmd_go(16'd20, 16'd1);
    repeat (6) @(negedge clk);
    total++; if (position !== 16'd6 || {quadA, quadB} !== 2'b11 || busy !== 1'b1) begin bad++; $display("FAIL reset_premove pos=%0d ab=%b busy=%b exp 6 11 1", position, {quadA, quadB}, busy); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (position !== 16'd0 || {quadA, quadB} !== 2'b00) begin bad++; $display("FAIL reset_async_pos pos=%0d ab=%b exp 0 00", position, {quadA, quadB}); end
    total++; if (busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL reset_async_flags busy=%b rdy=%b done=%b exp 0 1 0", busy, cmd_if.cmd_ready, done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_forward;
    int ep;
    cmd_go(16'd3, 16'd4);
    for (int n = 1; n <= 18; n++) begin
      if (n > 1) @(negedge clk);
      ep = (n >= 13) ? 3 : (n >= 9) ? 2 : (n >= 5) ? 1 : 0;
      total++; if (position !== 16'(ep) || {quadA, quadB} !== ab_of(ep)) begin bad++; $display("FAIL fwd_step n=%0d pos=%0d ab=%b exp %0d %b", n, position, {quadA, quadB}, ep, ab_of(ep)); end
      total++; if (done !== (n == 18) || busy !== (n < 18)) begin bad++; $display("FAIL fwd_done n=%0d done=%b busy=%b exp %b %b", n, done, busy, (n == 18), (n < 18)); end
    end
    total++; if (aborted !== 1'b0) begin bad++; $display("FAIL fwd_aborted got=%b exp 0", aborted); end
  endtask

  // Issued in the done cycle of the previous move, so it also proves back-to-back accept.
  task automatic test_reverse(input string tag);
    int ep;
    cmd_go(16'd0, 16'd0);
    for (int n = 1; n <= 6; n++) begin
      if (n > 1) @(negedge clk);
      ep = (n == 1) ? 3 : (n == 2) ? 2 : (n == 3) ? 1 : 0;
      total++; if (position !== 16'(ep) || {quadA, quadB} !== ab_of(ep)) begin bad++; $display("FAIL %s_step n=%0d pos=%0d ab=%b exp %0d %b", tag, n, position, {quadA, quadB}, ep, ab_of(ep)); end
      total++; if (done !== (n == 6) || aborted !== 1'b0) begin bad++; $display("FAIL %s_done n=%0d done=%b abt=%b exp %b 0", tag, n, done, aborted, (n == 6)); end
    end
  endtask

  task automatic test_abort;
    int ep;
    cmd_go(16'd100, 16'd2);
    for (int n = 1; n <= 9; n++) begin
      if (n > 1) @(negedge clk);
      ep = (n >= 7) ? 3 : (n >= 5) ? 2 : (n >= 3) ? 1 : 0;
      total++; if (position !== 16'(ep) || {quadA, quadB} !== ab_of(ep)) begin bad++; $display("FAIL abort_step n=%0d pos=%0d ab=%b exp %0d %b", n, position, {quadA, quadB}, ep, ab_of(ep)); end
      total++; if (done !== (n == 9) || aborted !== (n == 9)) begin bad++; $display("FAIL abort_done n=%0d done=%b abt=%b exp %b %b", n, done, aborted, (n == 9), (n == 9)); end
      abort = (n == 8);
    end
    total++; if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL abort_idle rdy=%b busy=%b exp 1 0", cmd_if.cmd_ready, busy); end
  endtask

  task automatic test_zero_handshake;
    int ep;
    cmd_go(16'd0, 16'd3);
    for (int n = 1; n <= 5; n++) begin
      if (n > 1) @(negedge clk);
      total++; if (position !== 16'd0 || {quadA, quadB} !== 2'b00) begin bad++; $display("FAIL zero_hold n=%0d pos=%0d ab=%b exp 0 00", n, position, {quadA, quadB}); end
      total++; if (done !== (n == 5) || cmd_if.cmd_ready !== (n == 5)) begin bad++; $display("FAIL zero_done n=%0d done=%b rdy=%b exp %b %b", n, done, cmd_if.cmd_ready, (n == 5), (n == 5)); end
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_target = 16'd5;
      cmd_if.cmd_period = 16'd1;
    end
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      if (n > 1) @(negedge clk);
      ep = (n < 2) ? 0 : (n > 6) ? 5 : n - 1;
      total++; if (position !== 16'(ep) || {quadA, quadB} !== ab_of(ep)) begin bad++; $display("FAIL held_step n=%0d pos=%0d ab=%b exp %0d %b", n, position, {quadA, quadB}, ep, ab_of(ep)); end
      total++; if (done !== (n == 8) || cmd_if.cmd_ready !== (n == 8)) begin bad++; $display("FAIL held_done n=%0d done=%b rdy=%b exp %b %b", n, done, cmd_if.cmd_ready, (n == 8), (n == 8)); end
    end
  endtask

  task automatic test_abort_in_idle;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if (done !== 1'b0 || aborted !== 1'b0 || cmd_if.cmd_ready !== 1'b1 || position !== 16'd5) begin bad++; $display("FAIL idle_abort done=%b abt=%b rdy=%b pos=%0d exp 0 0 1 5", done, aborted, cmd_if.cmd_ready, position); end
  endtask

  task automatic test_wrap;
    int exp5 [3][6];
    int tgts [3];
    int dn   [3];
    exp5 = '{'{0, 31, 30, 30, 30, 30}, '{30, 31, 0, 1, 1, 1}, '{1, 0, 31, 30, 30, 30}};
    tgts = '{30, 1, 30};
    dn   = '{5, 6, 6};
    for (int m = 0; m < 3; m++) begin
      cmd5_if.cmd_valid  = 1'b1;
      cmd5_if.cmd_target = 5'(tgts[m]);
      cmd5_if.cmd_period = 16'd1;
      @(negedge clk);
      cmd5_if.cmd_valid  = 1'b0;
      for (int n = 1; n <= dn[m]; n++) begin
        if (n > 1) @(negedge clk);
        total++; if (position5 !== 5'(exp5[m][n-1]) || {quadA5, quadB5} !== ab_of(exp5[m][n-1])) begin bad++; $display("FAIL wrap_step m=%0d n=%0d pos=%0d ab=%b exp %0d %b", m, n, position5, {quadA5, quadB5}, exp5[m][n-1], ab_of(exp5[m][n-1])); end
        total++; if (done5 !== (n == dn[m]) || aborted5 !== 1'b0) begin bad++; $display("FAIL wrap_done m=%0d n=%0d done=%b abt=%b exp %b 0", m, n, done5, aborted5, (n == dn[m])); end
      end
    end
  endtask

  initial begin
    cmd_if.cmd_valid   = 1'b0;
    cmd_if.cmd_target  = '0;
    cmd_if.cmd_period  = '0;
    cmd5_if.cmd_valid  = 1'b0;
    cmd5_if.cmd_target = '0;
    cmd5_if.cmd_period = '0;
    abort  = 1'b0;
    abort5 = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    test_reset();
    test_forward();
    test_reverse("rev");
    test_abort();
    test_reverse("post_abort");
    test_zero_handshake();
    test_abort_in_idle();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
